// File: rtl/cut_bist_ctrl_if.sv
// Host-side handshake bundle for the CUT BIST sequencer: run control,
// run configuration and the result/status returned after a run.
interface cut_bist_ctrl_if #(
  parameter int unsigned N_IN  = 20,
  parameter int unsigned N_OUT = 19,
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [N_IN-1:0]  seed;
  logic [CNT_W-1:0] n_patterns;
  logic [N_OUT-1:0] golden;
  logic             busy;
  logic             done;
  logic             pass;
  logic [N_OUT-1:0] signature;
  logic [CNT_W-1:0] pattern_cnt;

  // Test host side
  modport master (
    output start, abort, seed, n_patterns, golden,
    input  busy, done, pass, signature, pattern_cnt
  );

  // BIST controller side
  modport slave (
    input  start, abort, seed, n_patterns, golden,
    output busy, done, pass, signature, pattern_cnt
  );
endinterface

// File: rtl/cut_bist_ctrl.sv
// BIST sequencer for a 20-in / 19-out combinational CUT: LFSR pattern
// source, per-pattern settle delay, MISR response compaction and a final
// signature-vs-golden compare reported through a start/done handshake.
module cut_bist_ctrl #(
  parameter int unsigned N_IN       = 20,
  parameter int unsigned N_OUT      = 19,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  cut_bist_ctrl_if.slave   host,
  output logic [N_IN-1:0]  cut_x,
  input  logic [N_OUT-1:0] cut_f
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETTLE  = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_COMPARE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  logic [2:0]       state_q,  state_d;
  logic [3:0]       settle_q, settle_d;
  logic [N_IN-1:0]  lfsr_q,   lfsr_d;
  logic [N_OUT-1:0] misr_q,   misr_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [CNT_W-1:0] n_q,      n_d;
  logic [N_OUT-1:0] golden_q, golden_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic             pass_q,   pass_d;

  logic [N_IN-1:0]  lfsr_next;
  logic [N_OUT-1:0] misr_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             fb;

  // Next LFSR value (x^20+x^17+1) and MISR absorption of the CUT response (x^19+x^5+x^2+x+1)
  always_comb begin
    lfsr_next    = {lfsr_q[N_IN-2:0], lfsr_q[N_IN-1] ^ lfsr_q[N_IN-4]};
    fb           = misr_q[N_OUT-1];
    misr_next    = '0;
    misr_next[0] = fb ^ cut_f[0];
    for (int unsigned i = 1; i < N_OUT; i++) begin
      misr_next[i] = misr_q[i-1] ^ cut_f[i] ^ (((i == 1) || (i == 2) || (i == 5)) ? fb : 1'b0);
    end
    cnt_inc = cnt_q + 1'b1;
  end

  // Sequencer: run setup, settle/capture loop, terminal compare; abort overrides all
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    lfsr_d   = lfsr_q;
    misr_d   = misr_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    golden_d = golden_q;
    pass_d   = pass_q;

    case (state_q)
      S_IDLE: begin
        if (host.start && !host.abort) begin
          n_d      = host.n_patterns;
          golden_d = host.golden;
          lfsr_d   = (host.seed == '0) ? N_IN'(1) : host.seed;
          misr_d   = '0;
          cnt_d    = '0;
          pass_d   = 1'b0;
          settle_d = '0;
          state_d  = (host.n_patterns == '0) ? S_COMPARE : S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = S_CAPTURE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      S_CAPTURE: begin
        misr_d  = misr_next;
        lfsr_d  = lfsr_next;
        cnt_d   = cnt_inc;
        state_d = (cnt_inc == n_q) ? S_COMPARE : S_SETTLE;
      end
      S_COMPARE: begin
        pass_d  = (misr_q == golden_q);
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort undoes any update chosen above so pattern/signature/count stay frozen
    if (host.abort && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      settle_d = '0;
      lfsr_d   = lfsr_q;
      misr_d   = misr_q;
      cnt_d    = cnt_q;
      pass_d   = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      settle_q <= '0;
      lfsr_q   <= '0;
      misr_q   <= '0;
      cnt_q    <= '0;
      n_q      <= '0;
      golden_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      lfsr_q   <= lfsr_d;
      misr_q   <= misr_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      golden_q <= golden_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign cut_x            = lfsr_q;
  assign host.busy        = busy_q;
  assign host.done        = done_q;
  assign host.pass        = pass_q;
  assign host.signature   = misr_q;
  assign host.pattern_cnt = cnt_q;

endmodule

// File: tb/tb_cut_bist_ctrl.sv
// Self-checking bench for cut_bist_ctrl: a behavioural LFSR/MISR model
// predicts each run's result, which is queued at launch and compared when
// the DUT pulses done; directed checks cover reset, abort and start hold.
module tb_cut_bist_ctrl;

  localparam int unsigned SC = 2;

  typedef struct {
    logic [18:0] sig;
    logic        pass;
    logic [15:0] cnt;
    int unsigned lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] cut_x;
  logic [18:0] cut_f;
  int          mode;

  exp_t        sb_q[$];
  int unsigned cyc = 0;
  int unsigned accept_cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  logic [18:0] last_sig;
  logic        last_pass;

  cut_bist_ctrl_if #(.N_IN(20), .N_OUT(19), .CNT_W(16)) bif ();

  cut_bist_ctrl #(
    .N_IN(20), .N_OUT(19), .SETTLE_CYC(SC), .CNT_W(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .host  (bif),
    .cut_x (cut_x),
    .cut_f (cut_f)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in CUT behaviours
  function automatic logic [18:0] cut_model(input int md, input logic [19:0] x);
    case (md)
      0:       return 19'h00001;
      1:       return x[18:0] ^ {x[0], x[19:2]};
      2:       return (x == 20'h00001) ? 19'h40000 : 19'h00000;
      default: return 19'h00000;
    endcase
  endfunction

  always_comb cut_f = cut_model(mode, cut_x);

  function automatic logic [19:0] lfsr_step(input logic [19:0] l);
    return {l[18:0], l[19] ^ l[16]};
  endfunction

  // Polynomial form: shift, xor input, fold the dropped MSB back through taps 0,1,2,5
  function automatic logic [18:0] misr_step(input logic [18:0] m, input logic [18:0] f);
    logic [18:0] r;
    r = {m[17:0], 1'b0} ^ f;
    if (m[18]) r = r ^ 19'h00027;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Scoreboard consumer: every done pulse must match the oldest queued prediction
  always @(negedge clk) begin
    if (rst_n && bif.done) begin
      if (sb_q.size() == 0) begin
        check("done_unexpected", 32'(bif.done), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("signature", 32'(bif.signature), 32'(e.sig));
        check("pass", 32'(bif.pass), 32'(e.pass));
        check("pattern_cnt", 32'(bif.pattern_cnt), 32'(e.cnt));
        check("latency", cyc - accept_cyc + 1, e.lat);
        check("busy_at_done", 32'(bif.busy), 32'd1);
      end
    end
  end

  // Launch a run; called at posedge+1, returns at accept edge+1
  task automatic launch(input logic [19:0] sd, input logic [15:0] n, input logic [18:0] gold,
                        input int md, input bit model_gold, input bit expect_done,
                        input bit hold_start);
    logic [19:0] l;
    logic [18:0] m;
    exp_t        e;
    l = (sd == '0) ? 20'h00001 : sd;
    m = '0;
    for (int i = 0; i < int'(n); i++) begin
      m = misr_step(m, cut_model(md, l));
      l = lfsr_step(l);
    end
    if (model_gold) gold = m;
    e.sig  = m;
    e.pass = (m == gold);
    e.cnt  = n;
    e.lat  = int'(n) * (SC + 1) + 2;
    last_sig  = m;
    last_pass = e.pass;
    if (expect_done) sb_q.push_back(e);
    mode           = md;
    bif.seed       = sd;
    bif.n_patterns = n;
    bif.golden     = gold;
    bif.start      = 1'b1;
    @(posedge clk); #1;
    accept_cyc = cyc;
    if (!hold_start) bif.start = 1'b0;
  endtask

  task automatic tick(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done();
    int i;
    i = 0;
    while (sb_q.size() != 0 && i < 2000) begin
      @(posedge clk);
      i++;
    end
    #1;
    if (sb_q.size() != 0) begin
      check("done_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  initial begin
    mode = 0;
    rst_n = 1'b0;
    bif.start = 1'b0; bif.abort = 1'b0;
    bif.seed = '0; bif.n_patterns = '0; bif.golden = '0;
    #2;
    check("rst_busy", 32'(bif.busy), 32'd0);
    check("rst_done", 32'(bif.done), 32'd0);
    check("rst_pass", 32'(bif.pass), 32'd0);
    check("rst_cut_x", 32'(cut_x), 32'd0);
    check("rst_sig", 32'(bif.signature), 32'd0);
    check("rst_cnt", 32'(bif.pattern_cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(2);

    // Zero patterns
    launch(20'h00001, 16'd0, 19'h0, 0, 1'b0, 1'b1, 1'b0);
    check("zero_busy", 32'(bif.busy), 32'd1);
    wait_done();

    // Constant response, pattern hold and mid-run signature
    launch(20'h00001, 16'd2, 19'h00003, 0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check("const_hold_x", 32'(cut_x), 32'h00001);
      tick(1);
    end
    check("const_x2", 32'(cut_x), 32'h00002);
    check("const_sig1", 32'(bif.signature), 32'h00001);
    check("const_cnt1", 32'(bif.pattern_cnt), 32'd1);
    wait_done();
    tick(3);
    check("pass_held", 32'(bif.pass), 32'(last_pass));
    check("sig_held", 32'(bif.signature), 32'(last_sig));

    // Seed corner cases
    launch(20'h80000, 16'd2, 19'h0, 1, 1'b1, 1'b1, 1'b0);
    tick(3);
    check("seed_msb_x2", 32'(cut_x), 32'h00001);
    wait_done();
    launch(20'h00000, 16'd1, 19'h0, 1, 1'b1, 1'b1, 1'b0);
    check("seed_zero_x1", 32'(cut_x), 32'h00001);
    wait_done();

    // Signature mismatch
    launch(20'h00001, 16'd2, 19'h00004, 0, 1'b0, 1'b1, 1'b0);
    wait_done();

    // MISR feedback taps
    launch(20'h00001, 16'd2, 19'h00027, 2, 1'b0, 1'b1, 1'b0);
    tick(3);
    check("tap_sig1", 32'(bif.signature), 32'h40000);
    wait_done();

    // Abort during CAPTURE (after a passing run so pass starts high)
    launch(20'h00005, 16'd4, 19'h0, 1, 1'b0, 1'b0, 1'b0);
    tick(2);
    bif.abort = 1'b1;
    tick(1);
    bif.abort = 1'b0;
    check("abort_busy", 32'(bif.busy), 32'd0);
    check("abort_pass", 32'(bif.pass), 32'd0);
    check("abort_cut_x", 32'(cut_x), 32'h00005);
    check("abort_sig", 32'(bif.signature), 32'd0);
    check("abort_cnt", 32'(bif.pattern_cnt), 32'd0);
    tick(12);

    // Start held high for a whole run
    launch(20'h0ABCD, 16'd1, 19'h0, 1, 1'b1, 1'b1, 1'b1);
    wait_done();
    check("hold_idle_busy", 32'(bif.busy), 32'd0);
    tick(1);
    check("hold_rerun_busy", 32'(bif.busy), 32'd1);
    bif.start = 1'b0;
    bif.abort = 1'b1;
    tick(1);
    bif.abort = 1'b0;
    tick(6);

    // Start and abort together in IDLE
    bif.start = 1'b1; bif.abort = 1'b1;
    tick(1);
    bif.start = 1'b0; bif.abort = 1'b0;
    check("start_abort_idle", 32'(bif.busy), 32'd0);

    // Random runs, alternating matching and arbitrary golden
    for (int r = 0; r < 6; r++) begin
      launch(20'($urandom), 16'($urandom_range(1, 12)), 19'($urandom), 1, (r % 2) == 0, 1'b1, 1'b0);
      wait_done();
      tick(1);
    end

    // Reset during SETTLE
    launch(20'h12345, 16'd3, 19'h0, 1, 1'b0, 1'b0, 1'b0);
    tick(1);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_busy", 32'(bif.busy), 32'd0);
    check("mrst_cut_x", 32'(cut_x), 32'd0);
    check("mrst_sig", 32'(bif.signature), 32'd0);
    check("mrst_cnt", 32'(bif.pattern_cnt), 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(12);
    check("mrst_idle", 32'(bif.busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/cut_bist_ctrl.md
Name: cut_bist_ctrl

Overview:
- Built-in self-test sequencer for one 20-input / 19-output combinational benchmark circuit (CUT) from the generated dataset.
- Drives pseudo-random patterns from an LFSR onto the CUT inputs and waits a programmable number of settle cycles per pattern.
- Compacts the CUT outputs into a MISR signature, then compares the final signature against a golden value.
- Sits between a test host (start/done handshake) and the CUT's x/f pins.

Parameters:
- N_IN, 20, CUT input width; LFSR width (fixed polynomial below assumes 20).
- N_OUT, 19, CUT output width; MISR width (fixed polynomial below assumes 19).
- SETTLE_CYC, 2, cycles a pattern is held before capture; legal range 1..15.
- CNT_W, 16, pattern-count width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  run request; sampled only in IDLE.
- abort  in  1  cancel the run; returns to IDLE without asserting done.
- seed  in  N_IN  LFSR seed, latched on start; 0 is replaced by 1.
- n_patterns  in  CNT_W  number of patterns, latched on start.
- golden  in  N_OUT  expected signature, latched on start.
- cut_x  out  N_IN  pattern to the CUT (registered).
- cut_f  in  N_OUT  CUT response.
- busy  out  1  high from the cycle after start is accepted until DONE is exited.
- done  out  1  one-cycle pulse in the DONE state.
- pass  out  1  signature == golden; valid from done, held until the next start.
- signature  out  N_OUT  MISR value; held after the run.
- pattern_cnt  out  CNT_W  patterns captured so far.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; cut_x=0, busy=0, done=0, pass=0, signature=0, pattern_cnt=0, settle counter=0. Reset mid-run aborts silently.
- LFSR (Fibonacci, x^20+x^17+1): next = {lfsr[18:0], lfsr[19]^lfsr[16]}. cut_x is the LFSR register itself.
- MISR (x^19+x^5+x^2+x+1), with fb = misr[18]:
  - bit0 = fb ^ f[0]
  - bits 1, 2, 5 = misr[i-1] ^ f[i] ^ fb
  - all other bits = misr[i-1] ^ f[i]
- States: IDLE, SETTLE, CAPTURE, COMPARE, DONE.
- IDLE:
  - On start=1 and abort=0: latch n_patterns and golden; load LFSR with seed (or 1 if seed=0); clear signature, pattern_cnt and pass; busy=1.
  - Next state is COMPARE if n_patterns=0, otherwise SETTLE.
- SETTLE: hold cut_x for SETTLE_CYC cycles, counting up; then go to CAPTURE.
- CAPTURE (1 cycle), all updates at the same edge:
  - MISR absorbs cut_f.
  - LFSR advances.
  - pattern_cnt increments.
  - If pattern_cnt+1 == n_patterns go to COMPARE, otherwise return to SETTLE.
- COMPARE (1 cycle): pass <= (signature == golden_latched).
- DONE (1 cycle): done=1, busy=1; next state IDLE, where busy=0.
- Cycles per pattern: SETTLE_CYC+1.
- Total latency from the start-accept edge to the done cycle: n·(SETTLE_CYC+1)+2 cycles.
- abort in any non-IDLE state: next state IDLE; busy=0; done is not pulsed; pass=0. cut_x, signature and pattern_cnt are frozen. abort wins over every other transition.
- start while busy: ignored. start and abort both high in IDLE: stay in IDLE.
- pattern_cnt wraps modulo 2^CNT_W; it cannot exceed n_patterns because of the terminal compare.
- cut_f is sampled only in CAPTURE; it is don't-care elsewhere.

Test Plan:
- Reset mid-run: rst_n low during SETTLE -> all outputs 0 immediately (async), state IDLE, no done pulse.
- Zero patterns: seed=1, n_patterns=0, golden=0, start -> done exactly 2 cycles after the accept edge, pass=1, signature=0, pattern_cnt=0.
- Constant response: cut_f=0x00001, n=2, SETTLE_CYC=2, seed=1:
  - cut_x=0x00001 for 3 cycles, then 0x00002.
  - signature 0x00001 after pattern 1, 0x00003 at end.
  - golden=0x00003 -> pass=1; done 8 cycles after accept.
- Seed edge cases: seed=0x80000 -> second pattern 0x00001; seed=0 -> first pattern 0x00001.
- Mismatch and MISR tap check: n=2, golden=0x00004 -> pass=0, done still pulses. Force cut_f=0x40000 for one capture with misr=0 -> signature=0x40000; next capture with cut_f=0 -> 0x00027.
- Control edge cases:
  - abort asserted in CAPTURE -> IDLE next cycle, busy=0, no done.
  - start held high throughout a run -> exactly one run; a new run starts the cycle after DONE.
